// File: rtl/counter4_ctrl.sv
// counter4_ctrl: command-driven 4-bit prescaled counter with pause, abort, one-shot and auto-reload modes
module counter4_ctrl #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [3:0]         cmd_limit,
    input  logic               cmd_reload,
    input  logic [PRESC_W-1:0] cmd_presc,
    output logic [3:0]         count,
    output logic               busy,
    output logic               tc_pulse,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    state_e             state_q, state_d;
    logic [3:0]         count_q, count_d;
    logic [PRESC_W-1:0] psc_q, psc_d;
    logic [3:0]         limit_q, limit_d;
    logic               reload_q, reload_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tc_q, tc_d;
    logic               busy_q, done_q, ready_q;
    logic               accept, tick;

    // ready is low only in DONE, so accepted commands never land in DONE
    assign accept = cmd_valid && ready_q;
    assign tick   = (state_q == RUN) && (psc_q == presc_q);

    // next-state: a START/ABORT/PAUSE command pre-empts any tick in the same cycle; NOP lets the tick through
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        psc_d    = psc_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        tc_d     = 1'b0;
        if (accept && cmd_op == OP_START) begin
            limit_d  = cmd_limit;
            reload_d = cmd_reload;
            presc_d  = cmd_presc;
            count_d  = 4'd0;
            psc_d    = '0;
            state_d  = RUN;
        end else if (accept && cmd_op == OP_ABORT) begin
            count_d  = 4'd0;
            psc_d    = '0;
            state_d  = IDLE;
        end else if (accept && cmd_op == OP_PAUSE && state_q == RUN) begin
            state_d  = PAUSED;
        end else if (accept && cmd_op == OP_PAUSE && state_q == PAUSED) begin
            state_d  = RUN;
        end else if (state_q == DONE) begin
            state_d  = IDLE;
        end else if (state_q == RUN) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
            if (tick && count_q != limit_q) begin
                count_d = count_q + 4'd1;
            end else if (tick) begin
                tc_d    = 1'b1;
                count_d = reload_q ? 4'd0 : count_q;
                state_d = reload_q ? RUN : DONE;
            end
        end
    end

    // state and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= 4'd0;
            psc_q    <= '0;
            limit_q  <= 4'd0;
            reload_q <= 1'b0;
            presc_q  <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            psc_q    <= psc_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == RUN) || (state_d == PAUSED);
            done_q   <= (state_d == DONE);
            ready_q  <= (state_d != DONE);
        end
    end

    assign count     = count_q;
    assign busy      = busy_q;
    assign tc_pulse  = tc_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;

endmodule

// File: tb/tb_counter4_ctrl.sv
// tb_counter4_ctrl: directed table-driven and sequence checks for counter4_ctrl
module tb_counter4_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_limit = 4'd0;
    logic       cmd_reload = 1'b0;
    logic [3:0] cmd_presc = 4'd0;
    logic [3:0] count;
    logic       busy, tc_pulse, done;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [1:0] NOP = 2'b00, START = 2'b01, PAUSE = 2'b10, ABORT = 2'b11;

    typedef struct {
        logic       valid;
        logic [1:0] op;
        logic [3:0] lim;
        logic       rel;
        logic [3:0] presc;
        logic [3:0] e_count;
        logic       e_busy;
        logic       e_tc;
        logic       e_done;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[12];

    counter4_ctrl #(.PRESC_W(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_limit(cmd_limit), .cmd_reload(cmd_reload),
        .cmd_presc(cmd_presc), .count(count), .busy(busy), .tc_pulse(tc_pulse), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_all(input string nm, input logic [3:0] c, input logic b, input logic t,
                              input logic d, input logic r);
        chk({nm, ".count"}, 32'(count), 32'(c));
        chk({nm, ".busy"}, 32'(busy), 32'(b));
        chk({nm, ".tc"}, 32'(tc_pulse), 32'(t));
        chk({nm, ".done"}, 32'(done), 32'(d));
        chk({nm, ".ready"}, 32'(cmd_ready), 32'(r));
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [3:0] lim,
                        input logic rel, input logic [3:0] p);
        @(negedge clk);
        cmd_valid  = v;
        cmd_op     = op;
        cmd_limit  = lim;
        cmd_reload = rel;
        cmd_presc  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, NOP, 4'd0, 1'b0, 4'd0);
    endtask

    initial begin
        // one-shot limit=3, then START held through DONE, PAUSE/ABORT in IDLE
        vecs[0]  = '{1'b1, START, 4'd3, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, NOP,   4'd0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, NOP,   4'd0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, NOP,   4'd0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, NOP,   4'd0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, START, 4'd1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, START, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, NOP,   4'd0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, NOP,   4'd0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, NOP,   4'd0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, PAUSE, 4'd0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, ABORT, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};

        #12;
        expect_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].valid, vecs[i].op, vecs[i].lim, vecs[i].rel, vecs[i].presc);
            expect_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy,
                       vecs[i].e_tc, vecs[i].e_done, vecs[i].e_rdy);
        end

        // auto-reload limit=2 presc=2: increment every 3 cycles, tc every 9
        step(1'b1, START, 4'd2, 1'b1, 4'd2);
        expect_all("rl.start", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 20; j++) begin
            idle();
            expect_all($sformatf("rl.c%0d", j), 4'((j / 3) % 3), 1'b1, (j % 9) == 0, 1'b0, 1'b1);
        end
        step(1'b1, ABORT, 4'd0, 1'b0, 4'd0);
        expect_all("rl.abort", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // pause at count 5 for 4 cycles, resume, run to terminal count 15
        step(1'b1, START, 4'd15, 1'b0, 4'd0);
        expect_all("pz.start", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 5; j++) idle();
        chk("pz.pre", 32'(count), 32'd5);
        step(1'b1, PAUSE, 4'd0, 1'b0, 4'd0);
        expect_all("pz.pause", 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            idle();
            chk($sformatf("pz.hold%0d", j), 32'(count), 32'd5);
        end
        step(1'b1, PAUSE, 4'd0, 1'b0, 4'd0);
        expect_all("pz.resume", 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            idle();
            expect_all($sformatf("pz.run%0d", j), 4'(5 + j), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        idle();
        expect_all("pz.tc", 4'd15, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        expect_all("pz.idle", 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);

        // ABORT in the tick cycle at count==limit suppresses the terminal count
        step(1'b1, START, 4'd2, 1'b0, 4'd0);
        idle();
        idle();
        chk("ab.pre", 32'(count), 32'd2);
        step(1'b1, ABORT, 4'd0, 1'b0, 4'd0);
        expect_all("ab.abort", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        expect_all("ab.after", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-RUN between edges
        step(1'b1, START, 4'd4, 1'b0, 4'd0);
        idle();
        idle();
        chk("rs.pre", 32'(count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        expect_all("rs.async", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 8; j++) begin
            idle();
            expect_all($sformatf("rs.post%0d", j), 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, START, 4'd0, 1'b0, 4'd0);
        expect_all("rs.restart", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        expect_all("rs.lim0tc", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
